// File: rtl/dwc_axil_reg_slave_pkg.sv
// rtl/dwc_axil_reg_slave_pkg.sv - response codes, FSM state types and byte-strobe merge for the AXI4-Lite register slave
package dwc_axil_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT_DATA,
      W_WAIT_ADDR,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_t;

   function automatic logic [DATA_W-1:0] apply_wstrb(
      input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] data,
      input logic [STRB_W-1:0] strb
   );
      logic [DATA_W-1:0] res;
      res = old;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dwc_axil_reg_slave_if.sv
// rtl/dwc_axil_reg_slave_if.sv - AXI4-Lite bus bundle between the DWC core master and the register slave
interface dwc_axil_reg_slave_if #(
   parameter int ADDR_W = 6
) ();
   import dwc_axil_pkg::*;

   logic [ADDR_W-1:0] S_AXI_AWADDR;
   logic [2:0]        S_AXI_AWPROT;
   logic              S_AXI_AWVALID;
   logic              S_AXI_AWREADY;
   logic [DATA_W-1:0] S_AXI_WDATA;
   logic [STRB_W-1:0] S_AXI_WSTRB;
   logic              S_AXI_WVALID;
   logic              S_AXI_WREADY;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY;
   logic [ADDR_W-1:0] S_AXI_ARADDR;
   logic [2:0]        S_AXI_ARPROT;
   logic              S_AXI_ARVALID;
   logic              S_AXI_ARREADY;
   logic [DATA_W-1:0] S_AXI_RDATA;
   logic [1:0]        S_AXI_RRESP;
   logic              S_AXI_RVALID;
   logic              S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

endinterface

// File: rtl/dwc_axil_reg_slave_tmr_voter.sv
// rtl/dwc_axil_reg_slave_tmr_voter.sv - bitwise 2-of-3 majority voter with copy-mismatch flag
module dwc_tmr_voter #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   output logic [WIDTH-1:0] voted_o,
   output logic             mismatch_o
);

   assign voted_o    = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
   assign mismatch_o = (a_i != b_i) || (a_i != c_i);

endmodule

// File: rtl/dwc_axil_reg_slave.sv
// rtl/dwc_axil_reg_slave.sv - AXI4-Lite register bank with independent write/read FSMs and SLVERR on unmapped words
// Optional triple-redundant storage with scrubbing when DWC_REG_TMR_EN is defined.
module dwc_axil_reg_slave
   import dwc_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int NUM_REGS           = 4
) (
   input  logic                                 ACLK,
   input  logic                                 ARESET,
   dwc_axil_reg_slave_if.slave                  s_axi,
   output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_q,
   output logic                                 tmr_err
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

   typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;

   function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
      return ({1'b0, idx} < (IDX_W + 1)'(NUM_REGS));
   endfunction

   wr_state_t         wr_state_q, wr_state_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [IDX_W-1:0]  awidx_q, awidx_d;
   word_t             wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;

   logic              wr_commit;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   word_t             wr_data;
   logic [STRB_W-1:0] wr_strb;

   rd_state_t         rd_state_q, rd_state_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic [1:0]        rresp_q, rresp_d;
   word_t             rdata_q, rdata_d;
   word_t             rd_word;

   word_t             reg_val [NUM_REGS];

   logic              aw_hs, w_hs, ar_hs;
   logic [IDX_W-1:0]  aw_idx_in, ar_idx_in;
   logic              unused_bits;

   assign aw_hs     = s_axi.S_AXI_AWVALID && awready_q;
   assign w_hs      = s_axi.S_AXI_WVALID && wready_q;
   assign ar_hs     = s_axi.S_AXI_ARVALID && arready_q;
   assign aw_idx_in = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign ar_idx_in = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

   assign unused_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                          s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

   // Whichever of AW/W arrives second supplies its half live; the other half comes from the latch.
   always_comb begin
      wr_state_d = wr_state_q;
      awidx_d    = awidx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      wr_commit  = 1'b0;
      wr_idx     = awidx_q;
      wr_data    = wdata_q;
      wr_strb    = wstrb_q;
      case (wr_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_commit  = 1'b1;
               wr_idx     = aw_idx_in;
               wr_data    = s_axi.S_AXI_WDATA;
               wr_strb    = s_axi.S_AXI_WSTRB;
               wr_state_d = W_RESP;
            end else if (aw_hs) begin
               awidx_d    = aw_idx_in;
               wr_state_d = W_WAIT_DATA;
            end else if (w_hs) begin
               wdata_d    = s_axi.S_AXI_WDATA;
               wstrb_d    = s_axi.S_AXI_WSTRB;
               wr_state_d = W_WAIT_ADDR;
            end
         end
         W_WAIT_DATA: begin
            if (w_hs) begin
               wr_commit  = 1'b1;
               wr_data    = s_axi.S_AXI_WDATA;
               wr_strb    = s_axi.S_AXI_WSTRB;
               wr_state_d = W_RESP;
            end
         end
         W_WAIT_ADDR: begin
            if (aw_hs) begin
               wr_commit  = 1'b1;
               wr_idx     = aw_idx_in;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi.S_AXI_BREADY) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
      if (wr_commit) bresp_d = idx_ok(wr_idx) ? RESP_OKAY : RESP_SLVERR;
   end

   assign wr_en     = wr_commit && idx_ok(wr_idx);
   assign awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_WAIT_ADDR);
   assign wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_WAIT_DATA);
   assign bvalid_d  = (wr_state_d == W_RESP);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_state_q <= W_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         awidx_q    <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         awidx_q    <= awidx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
      end
   end

   // Unmapped indices match no register and fall through to zero.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ar_idx_in == IDX_W'(i)) rd_word = reg_val[i];
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               rdata_d    = rd_word;
               rresp_d    = idx_ok(ar_idx_in) ? RESP_OKAY : RESP_SLVERR;
               rd_state_d = R_RESP;
            end
         end
         R_RESP: begin
            if (s_axi.S_AXI_RREADY) rd_state_d = R_IDLE;
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   assign arready_d = (rd_state_d == R_IDLE);
   assign rvalid_d  = (rd_state_d == R_RESP);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rd_state_q <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

`ifdef DWC_REG_TMR_EN
   logic [NUM_REGS-1:0] reg_mism;
   logic                tmr_err_q;
`endif

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      localparam logic [IDX_W-1:0] IDX = IDX_W'(i);
      logic wr_hit;
      assign wr_hit = wr_en && (wr_idx == IDX);
`ifdef DWC_REG_TMR_EN
      word_t c0_q, c1_q, c2_q, voted;
      logic  mism;

      dwc_tmr_voter #(.WIDTH(C_S_AXI_DATA_WIDTH)) u_voter (
         .a_i        (c0_q),
         .b_i        (c1_q),
         .c_i        (c2_q),
         .voted_o    (voted),
         .mismatch_o (mism)
      );

      // A committing write overrides the scrub of the same register.
      always_ff @(posedge ACLK or posedge ARESET) begin
         if (ARESET) begin
            c0_q <= '0;
            c1_q <= '0;
            c2_q <= '0;
         end else if (wr_hit) begin
            c0_q <= apply_wstrb(voted, wr_data, wr_strb);
            c1_q <= apply_wstrb(voted, wr_data, wr_strb);
            c2_q <= apply_wstrb(voted, wr_data, wr_strb);
         end else if (mism) begin
            c0_q <= voted;
            c1_q <= voted;
            c2_q <= voted;
         end
      end

      assign reg_val[i]  = voted;
      assign reg_mism[i] = mism;
`else
      word_t val_q;

      always_ff @(posedge ACLK or posedge ARESET) begin
         if (ARESET) val_q <= '0;
         else if (wr_hit) val_q <= apply_wstrb(val_q, wr_data, wr_strb);
      end

      assign reg_val[i] = val_q;
`endif
      assign reg_q[C_S_AXI_DATA_WIDTH*i +: C_S_AXI_DATA_WIDTH] = reg_val[i];
   end

`ifdef DWC_REG_TMR_EN
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) tmr_err_q <= 1'b0;
      else if (|reg_mism) tmr_err_q <= 1'b1;
   end
   assign tmr_err = tmr_err_q;
`else
   assign tmr_err = 1'b0;
`endif

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;

endmodule
